// File: rtl/handshake_rr_buf.sv
// ============================================================================
// handshake_rr_buf : round-robin N-channel valid/ready merger into a show-ahead
//                    FIFO of {source channel, payload} words
// Revision: 1.0
// ============================================================================
`default_nettype none

module handshake_rr_buf #(
  parameter int DATA_W = 16,
  parameter int CH_NUM = 4,
  parameter int DEPTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        srst_n_i,
  input  logic [CH_NUM*DATA_W-1:0]    data_i,
  input  logic [CH_NUM-1:0]           data_val_i,
  output logic [CH_NUM-1:0]           data_ready_o,
  output logic [DATA_W-1:0]           data_o,
  output logic [$clog2(CH_NUM)-1:0]   data_ch_o,
  output logic                        data_val_o,
  input  logic                        data_ready_i,
  output logic [$clog2(DEPTH):0]      usedw_o
);

  localparam int c_CHW = $clog2(CH_NUM);
  localparam int c_AW  = $clog2(DEPTH);
  localparam int c_WW  = c_CHW + DATA_W;
  localparam logic [c_CHW:0] c_CH_NUM = (c_CHW+1)'(CH_NUM);
  localparam logic [c_AW:0]  c_DEPTH  = (c_AW+1)'(DEPTH);

  logic [c_CHW-1:0] r_rr_ptr;
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_usedw;
  logic [c_WW-1:0]  r_mem [DEPTH];

  logic             w_any;
  logic [c_CHW-1:0] w_grant;
  logic [c_CHW:0]   w_idx_ext;
  logic [c_CHW:0]   w_grant_inc;
  logic [c_CHW-1:0] w_rr_next;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  // First valid channel at or above the pointer, wrapping modulo CH_NUM.
  always_comb begin
    w_any     = 1'b0;
    w_grant   = '0;
    w_idx_ext = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_idx_ext = {1'b0, r_rr_ptr} + (c_CHW+1)'(i);
      if (w_idx_ext >= c_CH_NUM) begin
        w_idx_ext = w_idx_ext - c_CH_NUM;
      end
      if (!w_any && data_val_i[w_idx_ext[c_CHW-1:0]]) begin
        w_any   = 1'b1;
        w_grant = w_idx_ext[c_CHW-1:0];
      end
    end
  end

  assign w_grant_inc = {1'b0, w_grant} + (c_CHW+1)'(1);
  assign w_rr_next   = (w_grant_inc == c_CH_NUM) ? '0 : w_grant_inc[c_CHW-1:0];

  // A full buffer refuses input even when a pop frees a slot this cycle.
  assign w_full = (r_usedw == c_DEPTH);
  assign w_push = srst_n_i && w_any && !w_full;
  assign w_pop  = data_val_o && data_ready_i;

  assign data_ready_o = w_push ? (CH_NUM'(1) << w_grant) : '0;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
    end else begin
      if (w_push) begin
        r_rr_ptr <= w_rr_next;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_usedw <= r_usedw + 1'b1;
        2'b01:   r_usedw <= r_usedw - 1'b1;
        default: r_usedw <= r_usedw;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_grant, data_i[w_grant*DATA_W +: DATA_W]};
    end
  end

  assign data_val_o = (r_usedw != '0);
  assign data_o     = r_mem[r_rd_ptr][DATA_W-1:0];
  assign data_ch_o  = r_mem[r_rd_ptr][c_WW-1:DATA_W];
  assign usedw_o    = r_usedw;

endmodule

`default_nettype wire

// File: tb/tb_handshake_rr_buf.sv
// ============================================================================
// tb_handshake_rr_buf : directed + randomized scoreboard bench for the
//                       round-robin merging buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_handshake_rr_buf;

  localparam int DW  = 16;
  localparam int CH  = 4;
  localparam int DP  = 8;
  localparam int CHW = 2;
  localparam int UW  = 4;

  logic                clk_i = 1'b0;
  logic                srst_n_i = 1'b0;
  logic [CH*DW-1:0]    data_i = '0;
  logic [CH-1:0]       data_val_i = '0;
  logic [CH-1:0]       data_ready_o;
  logic [DW-1:0]       data_o;
  logic [CHW-1:0]      data_ch_o;
  logic                data_val_o;
  logic                data_ready_i = 1'b0;
  logic [UW-1:0]       usedw_o;

  handshake_rr_buf #(.DATA_W(DW), .CH_NUM(CH), .DEPTH(DP)) dut (
    .clk_i        (clk_i),
    .srst_n_i     (srst_n_i),
    .data_i       (data_i),
    .data_val_i   (data_val_i),
    .data_ready_o (data_ready_o),
    .data_o       (data_o),
    .data_ch_o    (data_ch_o),
    .data_val_o   (data_val_o),
    .data_ready_i (data_ready_i),
    .usedw_o      (usedw_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          chk;
    logic [CH-1:0] rdy;
    logic [UW-1:0] used;
  } st_t;

  st_t               sq[$];
  logic [CHW+DW-1:0] wq[$];
  int                m_rr  = 0;
  int                m_cnt = 0;
  bit                done  = 1'b0;
  int                n_total = 0;
  int                n_pass  = 0;

  // Reference model: arbitration by modular search, buffer as a queue.
  task automatic step(input logic [CH-1:0] v, input logic [CH*DW-1:0] d,
                      input logic r, input logic rst_n, input logic chk,
                      output logic pushed);
    int   g;
    logic popped;
    st_t  st;
    @(posedge clk_i);
    #1;
    data_val_i   = v;
    data_i       = d;
    data_ready_i = r;
    srst_n_i     = rst_n;
    g = -1;
    for (int i = 0; i < CH; i++) begin
      if (g < 0 && v[(m_rr + i) % CH]) g = (m_rr + i) % CH;
    end
    pushed  = rst_n && (g >= 0) && (m_cnt < DP);
    popped  = rst_n && (m_cnt > 0) && r;
    st.chk  = chk;
    st.used = UW'(m_cnt);
    st.rdy  = pushed ? (CH'(1) << g) : '0;
    sq.push_back(st);
    if (!rst_n) begin
      m_cnt = 0;
      m_rr  = 0;
      wq.delete();
    end else begin
      if (pushed) begin
        wq.push_back({CHW'(g), d[g*DW +: DW]});
        m_rr = (g + 1) % CH;
      end
      m_cnt = m_cnt + int'(pushed) - int'(popped);
    end
  endtask

  function automatic logic [CH*DW-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: status expectations every cycle, payload on each output handshake.
  initial begin
    st_t               st;
    logic [CHW+DW-1:0] w;
    forever begin
      @(negedge clk_i);
      if (sq.size() > 0) begin
        st = sq.pop_front();
        check("data_ready_o", 64'(data_ready_o), 64'(st.rdy));
        if (st.chk) begin
          check("usedw_o", 64'(usedw_o), 64'(st.used));
          check("data_val_o", 64'(data_val_o), 64'(st.used != '0));
        end
      end
      if (data_val_o === 1'b1 && data_ready_i === 1'b1) begin
        if (wq.size() == 0) begin
          check("pop_underflow", 64'(1), 64'(0));
        end else begin
          w = wq.pop_front();
          check("data_ch_o", 64'(data_ch_o), 64'(w[CHW+DW-1:DW]));
          check("data_o", 64'(data_o), 64'(w[DW-1:0]));
        end
      end
      if (done) begin
        check("leftover_words", 64'(wq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic             p;
    logic [CH*DW-1:0] d;
    int               c;
    step('0, '0, 1'b0, 1'b0, 1'b0, p);
    step('0, '0, 1'b0, 1'b0, 1'b1, p);
    step('0, '0, 1'b0, 1'b1, 1'b1, p);

    // Single word on channel 2.
    d = '0;
    d[2*DW +: DW] = 16'h00A5;
    step(4'b0100, d, 1'b1, 1'b1, 1'b1, p);
    repeat (3) step('0, '0, 1'b1, 1'b1, 1'b1, p);

    // All channels valid: strict rotation.
    repeat (10) step(4'b1111, rnd_data(), 1'b1, 1'b1, 1'b1, p);
    repeat (3) step('0, '0, 1'b1, 1'b1, 1'b1, p);

    // Fill from channel 0 with output stalled.
    c = 0;
    repeat (12) begin
      d = '0;
      d[DW-1:0] = DW'(c);
      step(4'b0001, d, 1'b0, 1'b1, 1'b1, p);
      if (p) c++;
    end
    // Full with simultaneous pop: channel 1 waits one cycle.
    d = '0;
    d[DW +: DW] = 16'h1111;
    repeat (2) step(4'b0010, d, 1'b1, 1'b1, 1'b1, p);
    repeat (20) begin
      d = '0;
      d[DW-1:0] = DW'(c);
      step((c < 10) ? 4'b0001 : 4'b0000, d, 1'b1, 1'b1, 1'b1, p);
      if (p) c++;
    end

    // Five words leaving the pointer at 3, then reset.
    for (int k = 0; k < 5; k++) begin
      step(CH'(1) << ((k + 1) % 3), rnd_data(), 1'b0, 1'b1, 1'b1, p);
    end
    step('0, '0, 1'b0, 1'b0, 1'b1, p);
    step(4'b1001, rnd_data(), 1'b0, 1'b1, 1'b1, p);
    repeat (3) step('0, '0, 1'b1, 1'b1, 1'b1, p);

    // Randomized traffic with occasional reset.
    repeat (500) begin
      if ($urandom_range(0, 59) == 0)
        step(CH'($urandom), rnd_data(), 1'b0, 1'b0, 1'b1, p);
      else
        step(CH'($urandom) & CH'($urandom_range(0, 15)), rnd_data(),
             ($urandom_range(0, 3) != 0), 1'b1, 1'b1, p);
    end

    repeat (DP + 4) step('0, '0, 1'b1, 1'b1, 1'b1, p);
    done = 1'b1;
  end

endmodule

`default_nettype wire
